// File: rtl/memory_access_unit_pkg.sv
// Shared types for the memory access unit: access size, exception mask and
// the acceptance-time exception check.
package memory_access_unit_pkg;

  // Access size requested by the core; 2'd3 is an illegal encoding.
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_access_t;

  // Exception mask reported with core_done; misaligned is bit 0.
  typedef struct packed {
    logic write_protect;
    logic illegal_access;
    logic out_of_range;
    logic misaligned;
  } mem_exception_mask_t;

  localparam int WORD_W = 32;

  // Every check is evaluated independently, so several bits may be set at once.
  function automatic mem_exception_mask_t mau_check(
    input logic [31:0] addr,
    input mem_access_t access,
    input logic        wr,
    input logic [3:0]  bank,
    input int          addr_bits,
    input logic        read_only
  );
    mem_exception_mask_t m;
    m = '0;
    case (access)
      MEM_BYTE, MEM_HALF, MEM_WORD: m.illegal_access = 1'b0;
      default:                      m.illegal_access = 1'b1;
    endcase
    m.misaligned    = ((access == MEM_HALF) && addr[0]) ||
                      ((access == MEM_WORD) && (addr[1:0] != 2'b00));
    m.out_of_range  = (addr[31:28] != bank) ||
                      ((addr[27:0] >> (addr_bits + 2)) != 28'd0);
    m.write_protect = wr && read_only;
    return m;
  endfunction

endpackage

// File: rtl/memory_access_unit_lane.sv
// Lane logic: extracts and extends a load lane from a RAM word, and merges a
// sub-word store into a RAM word for read-modify-write.
module mau_lane_logic
  import memory_access_unit_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        lane_i,
  input  mem_access_t       access_i,
  input  logic              signed_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] ld_data_o,
  output logic [WORD_W-1:0] st_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  shamt;
  logic [31:0] mask;

  // Select the addressed lane and build the merge mask for that lane.
  always_comb begin
    shamt     = {lane_i, 3'b000};
    ld_data_o = word_i;
    st_word_o = wdata_i;
    mask      = '0;
    case (lane_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    case (access_i)
      MEM_BYTE: begin
        ld_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
        mask      = 32'h0000_00FF << shamt;
        st_word_o = (word_i & ~mask) | ({24'b0, wdata_i[7:0]} << shamt);
      end
      MEM_HALF: begin
        ld_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
        mask      = 32'h0000_FFFF << shamt;
        st_word_o = (word_i & ~mask) | ({16'b0, wdata_i[15:0]} << shamt);
      end
      default: begin
        ld_data_o = word_i;
        st_word_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory access unit: turns core byte/half/word loads and stores into accesses
// on one word-wide synchronous RAM without byte enables (sub-word stores are
// read-modify-write), and reports alignment/range/type/protection faults.
module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter logic [3:0] BANK      = 4'h1,
  parameter int         ADDR_BITS = 10,
  parameter logic       READ_ONLY = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req,
  input  logic [31:0]           core_addr,
  input  logic                  core_wr_ena,
  input  logic [31:0]           core_wr_data,
  input  mem_access_t           core_access,
  input  logic                  core_signed,
  output logic                  core_busy,
  output logic                  core_done,
  output logic [31:0]           core_rd_data,
  output mem_exception_mask_t   core_exception,
  output logic [ADDR_BITS-1:0]  ram_addr,
  output logic                  ram_wr_ena,
  output logic [31:0]           ram_wr_data,
  input  logic [31:0]           ram_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] ram_addr_q;
  logic [1:0]           lane_q;
  logic                 wr_q;
  logic                 signed_q;
  mem_access_t          access_q;
  logic [31:0]          wdata_q;   // store data, replaced by the merged word in S_CAPTURE
  logic [31:0]          rdata_q;
  mem_exception_mask_t  exc_q;

  logic                 accept;
  mem_exception_mask_t  exc_now;
  logic [31:0]          ld_data;
  logic [31:0]          st_word;

  assign accept  = (state_q == S_IDLE) && core_req;
  assign exc_now = mau_check(core_addr, core_access, core_wr_ena, BANK, ADDR_BITS, READ_ONLY);

  mau_lane_logic u_lane (
    .word_i    (ram_rd_data),
    .lane_i    (lane_q),
    .access_i  (access_q),
    .signed_i  (signed_q),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: faults go straight to the response, word stores skip the read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (core_req) begin
          if (exc_now != '0)                                 state_d = S_RESP;
          else if (core_wr_ena && (core_access == MEM_WORD)) state_d = S_WRITE;
          else                                               state_d = S_READ;
        end
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = wr_q ? S_WRITE : S_RESP;
      S_WRITE:   state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; response data is zero outside S_RESP.
  always_comb begin
    core_busy      = (state_q != S_IDLE);
    core_done      = (state_q == S_RESP);
    core_rd_data   = (state_q == S_RESP) ? rdata_q : 32'd0;
    core_exception = (state_q == S_RESP) ? exc_q : '0;
    ram_wr_ena     = (state_q == S_WRITE);
    ram_wr_data    = (state_q == S_WRITE) ? wdata_q : 32'd0;
  end

  assign ram_addr = ram_addr_q;

  // Request latch at acceptance and lane result capture after the RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr_q <= '0;
      lane_q     <= '0;
      wr_q       <= 1'b0;
      signed_q   <= 1'b0;
      access_q   <= MEM_BYTE;
      wdata_q    <= '0;
      rdata_q    <= '0;
      exc_q      <= '0;
    end else begin
      if (accept) begin
        lane_q   <= core_addr[1:0];
        wr_q     <= core_wr_ena;
        signed_q <= core_signed;
        access_q <= core_access;
        wdata_q  <= core_wr_data;
        rdata_q  <= '0;
        exc_q    <= exc_now;
        // A faulting access never touches the RAM, so the address holds.
        if (exc_now == '0) ram_addr_q <= core_addr[ADDR_BITS+1:2];
      end
      if (state_q == S_CAPTURE) begin
        if (wr_q) wdata_q <= st_word;
        else      rdata_q <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench: two units (writable and read-only) on bench RAM models.
module tb_memory_access_unit;
  import memory_access_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic wr = 1'b0, sgn = 1'b0;
  mem_access_t access = MEM_BYTE;

  logic busy0, done0, rwe0, busy1, done1, rwe1;
  logic [31:0] rd0, rwd0, rrd0, rd1, rwd1, rrd1;
  mem_exception_mask_t exc0, exc1;
  logic [9:0] raddr0, raddr1;

  logic [31:0] mem0 [0:1023];
  logic [31:0] mem1 [0:1023];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  memory_access_unit #(.BANK(4'h1), .ADDR_BITS(10), .READ_ONLY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .core_req(req0), .core_addr(addr), .core_wr_ena(wr),
    .core_wr_data(wdata), .core_access(access), .core_signed(sgn),
    .core_busy(busy0), .core_done(done0), .core_rd_data(rd0), .core_exception(exc0),
    .ram_addr(raddr0), .ram_wr_ena(rwe0), .ram_wr_data(rwd0), .ram_rd_data(rrd0));

  memory_access_unit #(.BANK(4'h1), .ADDR_BITS(10), .READ_ONLY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .core_req(req1), .core_addr(addr), .core_wr_ena(wr),
    .core_wr_data(wdata), .core_access(access), .core_signed(sgn),
    .core_busy(busy1), .core_done(done1), .core_rd_data(rd1), .core_exception(exc1),
    .ram_addr(raddr1), .ram_wr_ena(rwe1), .ram_wr_data(rwd1), .ram_rd_data(rrd1));

  // Synchronous RAMs, one-cycle read latency.
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 1024; i++) begin
        mem0[i] <= 32'd0;
        mem1[i] <= 32'd0;
      end
      mem0[0] <= 32'h8899AABB;
      mem1[0] <= 32'hCAFEF00D;
    end else begin
      if (rwe0) mem0[raddr0] <= rwd0;
      if (rwe1) mem1[raddr1] <= rwd1;
    end
    rrd0 <= mem0[raddr0];
    rrd1 <= mem1[raddr1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One access; latency and write pulse cycle are counted from acceptance.
  task automatic run_op(input bit sel, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [1:0] acc, input logic sg,
                        output int lat, output logic [31:0] rd, output logic [3:0] ex,
                        output int nwr, output int wr_at, output logic [31:0] wdat);
    @(negedge clk);
    addr = a; wr = w; wdata = d; access = mem_access_t'(acc); sgn = sg;
    if (sel) req1 = 1'b1; else req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    lat = -1; nwr = 0; wr_at = -1; wdat = '0; rd = '0; ex = '0;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(negedge clk);
      if (sel ? rwe1 : rwe0) begin
        nwr++; wr_at = k; wdat = sel ? rwd1 : rwd0;
      end
      if (sel ? done1 : done0) begin
        lat = k; rd = sel ? rd1 : rd0; ex = sel ? exc1 : exc0;
      end
    end
  endtask

  task automatic check_op(input string tag, input bit sel, input logic [31:0] a,
                          input logic w, input logic [31:0] d, input logic [1:0] acc,
                          input logic sg, input logic [31:0] exp_rd, input logic [3:0] exp_ex,
                          input int exp_lat, input int exp_nwr, input logic [31:0] exp_wdat);
    int lat, nwr, wr_at;
    logic [31:0] rd, wdat;
    logic [3:0] ex;
    run_op(sel, a, w, d, acc, sg, lat, rd, ex, nwr, wr_at, wdat);
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".rd"}, rd, exp_rd);
    chk({tag, ".exc"}, {28'd0, ex}, {28'd0, exp_ex});
    chk({tag, ".nwr"}, nwr, exp_nwr);
    if (exp_nwr > 0) begin
      chk({tag, ".wr_at"}, wr_at, exp_lat - 1);
      chk({tag, ".wdata"}, wdat, exp_wdat);
    end
  endtask

  initial begin
    int nbad_wr, nbad_done, d1, d2, busy_err;
    logic [31:0] r1, r2;
    logic bz [1:12];

    repeat (3) @(posedge clk);
    #1 init = 1'b0;
    @(negedge clk);
    chk("rst.busy", busy0, 0);
    chk("rst.done", done0, 0);
    chk("rst.rd", rd0, 0);
    chk("rst.exc", exc0, 0);
    chk("rst.ram_addr", raddr0, 0);
    chk("rst.wr_ena", rwe0, 0);
    chk("rst.wr_data", rwd0, 0);
    rst = 1'b0;

    // Loads: byte signed, half unsigned, word
    check_op("lb_s",  0, 32'h10000001, 0, 32'h0, 2'd0, 1, 32'hFFFFFFAA, 4'h0, 3, 0, 0);
    check_op("lh_u",  0, 32'h10000002, 0, 32'h0, 2'd1, 0, 32'h00008899, 4'h0, 3, 0, 0);
    check_op("lw",    0, 32'h10000000, 0, 32'h0, 2'd2, 1, 32'h8899AABB, 4'h0, 3, 0, 0);
    // Sub-word store uses only the low byte of the data
    check_op("sb",    0, 32'h10000002, 1, 32'h12345655, 2'd0, 0, 32'h0, 4'h0, 4, 1, 32'h8855AABB);
    check_op("lw2",   0, 32'h10000000, 0, 32'h0, 2'd2, 0, 32'h8855AABB, 4'h0, 3, 0, 0);
    check_op("sw",    0, 32'h10000014, 1, 32'hDEADBEEF, 2'd2, 0, 32'h0, 4'h0, 2, 1, 32'hDEADBEEF);
    check_op("sh",    0, 32'h10000016, 1, 32'hFFFFBEEF, 2'd1, 0, 32'h0, 4'h0, 4, 1, 32'hBEEFBEEF);
    check_op("lh_s",  0, 32'h10000016, 0, 32'h0, 2'd1, 1, 32'hFFFFBEEF, 4'h0, 3, 0, 0);
    check_op("lb_u",  0, 32'h10000017, 0, 32'h0, 2'd0, 0, 32'h000000BE, 4'h0, 3, 0, 0);
    // Last word of the bank is in range
    check_op("lw_top", 0, 32'h10000FFC, 0, 32'h0, 2'd2, 0, 32'h0, 4'h0, 3, 0, 0);
    check_op("sw_idx5", 0, 32'h10000014, 1, 32'h0BADF00D, 2'd2, 0, 32'h0, 4'h0, 2, 1, 32'h0BADF00D);
    // Faults: no RAM activity, address holds at idx 5
    check_op("mis_lw", 0, 32'h10000002, 0, 32'h0, 2'd2, 0, 32'h0, 4'h1, 1, 0, 0);
    chk("mis_lw.ram_addr", raddr0, 5);
    check_op("oor_lw", 0, 32'h20000000, 0, 32'h0, 2'd2, 0, 32'h0, 4'h2, 1, 0, 0);
    chk("oor_lw.ram_addr", raddr0, 5);
    check_op("oor_hi", 0, 32'h10001000, 0, 32'h0, 2'd2, 0, 32'h0, 4'h2, 1, 0, 0);
    check_op("mis_oor", 0, 32'h20000002, 0, 32'h0, 2'd2, 0, 32'h0, 4'h3, 1, 0, 0);
    check_op("ill_st", 0, 32'h10000001, 1, 32'h0, 2'd3, 0, 32'h0, 4'h4, 1, 0, 0);
    check_op("mis_sh", 0, 32'h10000001, 1, 32'h1234, 2'd1, 0, 32'h0, 4'h1, 1, 0, 0);
    check_op("lw_idx5", 0, 32'h10000014, 0, 32'h0, 2'd2, 0, 32'h0BADF00D, 4'h0, 3, 0, 0);

    // Read-only unit
    check_op("ro_sw",  1, 32'h10000000, 1, 32'h11111111, 2'd2, 0, 32'h0, 4'h8, 1, 0, 0);
    check_op("ro_lw",  1, 32'h10000000, 0, 32'h0, 2'd2, 0, 32'hCAFEF00D, 4'h0, 3, 0, 0);
    check_op("ro_oor", 1, 32'h30000001, 1, 32'h0, 2'd0, 0, 32'h0, 4'hA, 1, 0, 0);

    // Reset during S_CAPTURE of a half store
    @(negedge clk);
    addr = 32'h10000014; wr = 1'b1; wdata = 32'h00001234; access = MEM_HALF; sgn = 1'b0;
    req0 = 1'b1;
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    nbad_wr = 0; nbad_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rwe0) nbad_wr++;
      if (done0) nbad_done++;
      if (k == 1) rst = 1'b0;
    end
    chk("rst_mid.no_wr", nbad_wr, 0);
    chk("rst_mid.no_done", nbad_done, 0);
    chk("rst_mid.busy", busy0, 0);
    check_op("rst_mid.mem", 0, 32'h10000014, 0, 32'h0, 2'd2, 0, 32'h0BADF00D, 4'h0, 3, 0, 0);

    // Back-to-back loads with req held high
    @(negedge clk);
    addr = 32'h10000000; wr = 1'b0; access = MEM_WORD; sgn = 1'b0;
    req0 = 1'b1;
    @(posedge clk);
    d1 = -1; d2 = -1; r1 = '0; r2 = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bz[k] = busy0;
      if (done0 && d1 < 0) begin d1 = k; r1 = rd0; end
      else if (done0 && d2 < 0) begin d2 = k; r2 = rd0; req0 = 1'b0; end
      if (d2 > 0) break;
    end
    req0 = 1'b0;
    chk("b2b.d1", d1, 3);
    chk("b2b.d2", d2, 7);
    chk("b2b.rd1", r1, 32'h8855AABB);
    chk("b2b.rd2", r2, 32'h8855AABB);
    busy_err = 0;
    if (d2 == 7) begin
      for (int k = 1; k <= 7; k++)
        if (bz[k] !== ((k == 4) ? 1'b0 : 1'b1)) busy_err++;
    end
    chk("b2b.busy", busy_err, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
